// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS fetch stage.
//   fetch_state_e  - fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t  - one instruction-queue entry: {instr, pc4}
//   WORD_W, INSTR_BYTES, NOP
//   next_pc()      - sequential PC increment with natural 32-bit wrap
//   sat_add32()    - saturating 32-bit add used by the optional perf counters
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(INSTR_BYTES);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched instruction entries.
// The head entry is always visible on rdata (no read strobe); flush has
// priority over push and pop.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write an entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   flush           discard every entry
//   rdata           head entry
//   count, full, empty  occupancy status
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset: the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues one word fetch at a time to a handshaked instruction
// memory, buffers returned words in fetch_fifo and presents the queue head
// to decode as an {instruction, PC+4} pair.
// Ports:
//   Clk, Rst                     clock, asynchronous active-high reset
//   imem_req/imem_addr           fetch request (held until imem_ready)
//   imem_ready                   memory accepts the request this cycle
//   imem_rvalid/imem_rdata       in-order response, one per accepted request
//   id_stall                     decode holds the current instruction
//   redirect/redirect_pc         taken branch/jump from decode
//   if_valid/if_instr/if_pc4     queue head towards IF/ID
// Build option FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module mips_fetch_queue import mips_pkg::*; #(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                QDEPTH   = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] fetch_pc;

  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_after;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              accept;
  logic              space_after;

  assign accept   = imem_req && imem_ready;
  assign fetch_pc = redirect ? redirect_pc : pc;

  // A response that coincides with a redirect belongs to the wrong path.
  assign push = (state == WAIT) && imem_rvalid && !redirect && !fifo_full;
  assign pop  = if_valid && !id_stall && !redirect;

  // Occupancy after this edge; a new request is only launched if its reply
  // is guaranteed a slot, so the queue can never overflow.
  assign count_after = redirect ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));
  assign space_after = (count_after < CNT_W'(QDEPTH));

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc4   = next_pc(imem_addr);

  fetch_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign if_valid = !fifo_empty;
  assign if_instr = if_valid ? head_entry.instr : NOP;
  assign if_pc4   = if_valid ? head_entry.pc4   : '0;

  // imem_addr only moves when (re)entering REQ or on an unaccepted redirect,
  // so it stays stable while the memory withholds imem_ready and still names
  // the outstanding word while waiting for its reply.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc <= fetch_pc;
          if (space_after) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (accept) begin
            // A redirect racing the accept leaves a stale reply in flight.
            imem_req <= 1'b0;
            pc       <= redirect ? redirect_pc : next_pc(pc);
            state    <= redirect ? DROP : WAIT;
          end else if (redirect) begin
            pc        <= redirect_pc;
            imem_addr <= redirect_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_rvalid) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= redirect_pc;
            end else begin
              state <= DROP;
            end
          end else if (imem_rvalid) begin
            if (space_after) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          pc <= fetch_pc;
          if (imem_rvalid) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] drop_inc;

  // Dropped work = stale replies thrown away plus entries lost to a flush.
  assign discard  = imem_rvalid && ((state == DROP) || ((state == WAIT) && redirect));
  assign drop_inc = (redirect ? 32'(fifo_count) : 32'd0) + 32'(discard);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= sat_add32(perf_fetched, 32'(push));
      perf_dropped <= sat_add32(perf_dropped, drop_inc);
    end
  end
`endif

endmodule
